// File: rtl/inst_fetcher_pkg.sv
// Shared widths, FSM encodings and queue entry type
// for the instruction fetcher.
package inst_fetcher_pkg;

   localparam int InstWidth = 32;
   localparam int AddrWidth = 32;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   typedef struct packed {
      logic [InstWidth-1:0] inst;
      logic [AddrWidth-1:0] pc;
   } q_entry_t;

   function automatic logic [AddrWidth-1:0] next_pc(
      input logic [AddrWidth-1:0] pc
   );
      return pc + AddrWidth'(4);
   endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory-controller and decoder handshake bundle.
// master = fetcher side, slave = environment side.
interface inst_fetcher_if;
   import inst_fetcher_pkg::*;

   logic                 fetch_req;
   logic [AddrWidth-1:0] fetch_addr;
   logic                 mc_done;
   logic [InstWidth-1:0] mc_inst;
   logic                 dec_valid;
   logic [InstWidth-1:0] dec_inst;
   logic [AddrWidth-1:0] dec_pc;
   logic                 dec_ready;

   modport master (
      output fetch_req, fetch_addr,
      input  mc_done, mc_inst,
      output dec_valid, dec_inst, dec_pc,
      input  dec_ready
   );

   modport slave (
      input  fetch_req, fetch_addr,
      output mc_done, mc_inst,
      input  dec_valid, dec_inst, dec_pc,
      output dec_ready
   );

endinterface

// File: rtl/inst_fetcher_queue.sv
// Instruction queue: circular buffer of {inst, pc}.
// Head data reads as zero while empty.
module inst_queue
   import inst_fetcher_pkg::*;
#(
   parameter int QUEUE_DEPTH = 16
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  logic     flush,
   input  q_entry_t wdata,
   output q_entry_t data,
   output logic     full,
   output logic     empty
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] One = (PW+1)'(1);

   q_entry_t    mem_q [QUEUE_DEPTH];
   q_entry_t    mem_d [QUEUE_DEPTH];
   logic [PW:0] wr_q, wr_d;
   logic [PW:0] rd_q, rd_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q[PW-1:0]] = wdata;
            wr_d = wr_q + One;
         end
         if (pop) rd_d = rd_q + One;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

   // Extra pointer bit separates full from empty.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PW] != rd_q[PW]) &&
                  (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign data  = empty ? '0 : mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: PC register, IDLE/WAIT fetch FSM
// and an instruction queue feeding the decoder.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int                   QUEUE_DEPTH = 16,
   parameter logic [AddrWidth-1:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clr,
   input  logic [AddrWidth-1:0] clr_pc,
   inst_fetcher_if.master       bus
);

   logic [0:0]           state_q, state_d;
   logic [AddrWidth-1:0] pc_q, pc_d;
   logic                 push, pop, flush;
   logic                 full, empty;
   q_entry_t             wdata, head;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      if (rdy) begin
         // Redirect wins over any completion or pop.
         if (clr) begin
            flush   = 1'b1;
            pc_d    = clr_pc;
            state_d = StIdle;
         end else begin
            pop = !empty && bus.dec_ready;
            unique case (1'b1)
               (state_q == StIdle): begin
                  if (!full) state_d = StWait;
               end
               (state_q == StWait): begin
                  if (bus.mc_done) begin
                     push    = 1'b1;
                     pc_d    = next_pc(pc_q);
                     state_d = StIdle;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign wdata.inst = bus.mc_inst;
   assign wdata.pc   = pc_q;

   inst_queue #(
      .QUEUE_DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wdata),
      .data  (head),
      .full  (full),
      .empty (empty)
   );

   assign bus.fetch_req  = (state_q == StWait);
   assign bus.fetch_addr = bus.fetch_req ? pc_q : '0;
   assign bus.dec_valid  = !empty;
   assign bus.dec_inst   = head.inst;
   assign bus.dec_pc     = head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed vector bench for inst_fetcher.
module tb_inst_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clr;
   logic [31:0] clr_pc;
   int          n_tests = 0;
   int          n_fail  = 0;

   inst_fetcher_if bus();

   inst_fetcher #(
      .QUEUE_DEPTH (16),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rdy    (rdy),
      .clr    (clr),
      .clr_pc (clr_pc),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        clr;
      logic [31:0] clr_pc;
      logic        mc;
      logic [31:0] inst;
      logic        dr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_dv;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tv [22];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_req(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.fetch_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Answers n requests, one cycle into WAIT each.
   task automatic serve(input int n);
      logic ok;
      for (int k = 0; k < n; k++) begin
         wait_req(ok);
         chk("serve_timeout", 32'(ok), 32'd1);
         bus.mc_done = 1'b1;
         bus.mc_inst = inst_of(bus.fetch_addr);
         @(negedge clk);
         bus.mc_done = 1'b0;
      end
   endtask

   initial begin
      logic ok;
      logic [32*3+1:0] got_v, exp_v;

      // rdy clr clr_pc mc inst dr | req addr dv inst pc
      tv[0]  = '{1,0,0,0,0,0, 1,32'h0,0,0,0};
      tv[1]  = '{1,0,0,0,0,0, 1,32'h0,0,0,0};
      tv[2]  = '{1,0,0,1,32'hAAAA_0000,0, 0,0,1,32'hAAAA_0000,32'h0};
      tv[3]  = '{1,0,0,0,0,0, 1,32'h4,1,32'hAAAA_0000,32'h0};
      tv[4]  = '{1,0,0,0,0,0, 1,32'h4,1,32'hAAAA_0000,32'h0};
      tv[5]  = '{1,0,0,1,32'hBBBB_0004,0, 0,0,1,32'hAAAA_0000,32'h0};
      tv[6]  = '{1,0,0,0,0,1, 1,32'h8,1,32'hBBBB_0004,32'h4};
      tv[7]  = '{1,0,0,1,32'hCCCC_0008,1, 0,0,1,32'hCCCC_0008,32'h8};
      tv[8]  = '{1,0,0,0,0,1, 1,32'hC,0,0,0};
      tv[9]  = '{0,0,0,1,32'hDDDD_0000,1, 1,32'hC,0,0,0};
      tv[10] = '{0,0,0,1,32'hDDDD_0001,1, 1,32'hC,0,0,0};
      tv[11] = '{1,0,0,1,32'hEEEE_000C,0, 0,0,1,32'hEEEE_000C,32'hC};
      tv[12] = '{1,1,32'h1000,0,0,1, 0,0,0,0,0};
      tv[13] = '{1,0,0,0,0,0, 1,32'h1000,0,0,0};
      tv[14] = '{1,1,32'h2000,1,32'hF00D_F00D,0, 0,0,0,0,0};
      tv[15] = '{1,0,0,0,0,0, 1,32'h2000,0,0,0};
      tv[16] = '{1,0,0,1,32'h1111_1111,0, 0,0,1,32'h1111_1111,32'h2000};
      tv[17] = '{1,1,32'hFFFF_FFFC,0,0,0, 0,0,0,0,0};
      tv[18] = '{1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0};
      tv[19] = '{1,0,0,1,32'h2222_2222,0,
                 0,0,1,32'h2222_2222,32'hFFFF_FFFC};
      tv[20] = '{1,0,0,0,0,1, 1,32'h0,0,0,0};
      tv[21] = '{1,0,0,1,32'h3333_3333,0, 0,0,1,32'h3333_3333,32'h0};

      rst = 1'b0;
      rdy = 1'b1;
      clr = 1'b0;
      clr_pc = '0;
      bus.mc_done = 1'b0;
      bus.mc_inst = '0;
      bus.dec_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(bus.fetch_req), 32'd0);
      chk("rst_addr", bus.fetch_addr, 32'h0);
      chk("rst_dv", 32'(bus.dec_valid), 32'd0);
      chk("rst_inst", bus.dec_inst, 32'h0);
      chk("rst_pc", bus.dec_pc, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         rdy = tv[i].rdy;
         clr = tv[i].clr;
         clr_pc = tv[i].clr_pc;
         bus.mc_done = tv[i].mc;
         bus.mc_inst = tv[i].inst;
         bus.dec_ready = tv[i].dr;
         @(negedge clk);
         got_v = {bus.fetch_req, bus.fetch_addr, bus.dec_valid,
                  bus.dec_inst, bus.dec_pc};
         exp_v = {tv[i].e_req, tv[i].e_addr, tv[i].e_dv,
                  tv[i].e_inst, tv[i].e_pc};
         n_tests++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL vec%0d: got req=%b addr=%h dv=%b inst=%h pc=%h expected req=%b addr=%h dv=%b inst=%h pc=%h",
                     i, bus.fetch_req, bus.fetch_addr, bus.dec_valid,
                     bus.dec_inst, bus.dec_pc, tv[i].e_req,
                     tv[i].e_addr, tv[i].e_dv, tv[i].e_inst,
                     tv[i].e_pc);
         end
      end
      rdy = 1'b1;
      clr = 1'b0;
      bus.mc_done = 1'b0;
      bus.dec_ready = 1'b0;

      // Fill the queue, then confirm no request while full.
      clr = 1'b1;
      clr_pc = 32'h0;
      @(negedge clk);
      clr = 1'b0;
      serve(16);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("full_no_req", 32'(bus.fetch_req), 32'd0);
      end
      chk("full_head", bus.dec_pc, 32'h0);
      bus.dec_ready = 1'b1;
      @(negedge clk);
      bus.dec_ready = 1'b0;
      wait_req(ok);
      chk("refill_req", 32'(ok), 32'd1);
      chk("refill_addr", bus.fetch_addr, 32'h40);
      serve(1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("refull_no_req", 32'(bus.fetch_req), 32'd0);
      end
      for (int k = 0; k < 16; k++) begin
         chk("drain_dv", 32'(bus.dec_valid), 32'd1);
         chk("drain_pc", bus.dec_pc, 32'(4 + 4 * k));
         chk("drain_inst", bus.dec_inst, inst_of(32'(4 + 4 * k)));
         bus.dec_ready = 1'b1;
         @(negedge clk);
      end
      bus.dec_ready = 1'b0;

      // Three queued, fourth pending, then rdy low.
      clr = 1'b1;
      clr_pc = 32'h100;
      @(negedge clk);
      clr = 1'b0;
      serve(3);
      wait_req(ok);
      chk("pend_req", 32'(ok), 32'd1);
      chk("pend_addr", bus.fetch_addr, 32'h10C);
      rdy = 1'b0;
      bus.mc_done = 1'b1;
      bus.mc_inst = 32'hBAD0_BAD0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_req", 32'(bus.fetch_req), 32'd1);
         chk("hold_addr", bus.fetch_addr, 32'h10C);
         chk("hold_head", bus.dec_pc, 32'h100);
      end
      rdy = 1'b1;
      bus.mc_done = 1'b0;
      @(negedge clk);
      chk("resume_req", 32'(bus.fetch_req), 32'd1);
      chk("resume_addr", bus.fetch_addr, 32'h10C);
      chk("resume_dv", 32'(bus.dec_valid), 32'd1);

      // Asynchronous reset in the middle of WAIT.
      #2 rst = 1'b0;
      #1;
      chk("arst_req", 32'(bus.fetch_req), 32'd0);
      chk("arst_dv", 32'(bus.dec_valid), 32'd0);
      chk("arst_addr", bus.fetch_addr, 32'h0);
      chk("arst_inst", bus.dec_inst, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_req", 32'(bus.fetch_req), 32'd1);
      chk("post_rst_addr", bus.fetch_addr, 32'h0);
      chk("post_rst_dv", 32'(bus.dec_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter QUEUE_DEPTH, default 16, instruction queue entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global enable; when low, all state holds.
REQ-006 clr  input  1  pipeline flush/redirect, sampled synchronously.
REQ-007 clr_pc  input  32  redirect target, valid with clr.
REQ-008 fetch_req  output  1  fetch request to the memory controller.
REQ-009 fetch_addr  output  32  byte address of the requested instruction.
REQ-010 mc_done  input  1  memory controller pulse: mc_inst valid this cycle.
REQ-011 mc_inst  input  32  fetched instruction word.
REQ-012 dec_valid  output  1  queue head is valid for the decoder.
REQ-013 dec_inst  output  32  queue-head instruction.
REQ-014 dec_pc  output  32  queue-head PC.
REQ-015 dec_ready  input  1  decoder accepts the head this cycle.

Function
REQ-016 The block SHALL keep a PC register, a QUEUE_DEPTH-entry FIFO of {inst, pc}, and a 2-state FSM: IDLE and WAIT.
REQ-017 IDLE -> WAIT SHALL occur when rdy=1, clr=0 and queue count < QUEUE_DEPTH; in that cycle the block drives fetch_req=1 and fetch_addr=PC.
REQ-018 In WAIT, fetch_req SHALL stay at 1 and fetch_addr SHALL stay stable until mc_done=1.
REQ-019 On mc_done=1 in WAIT, the block SHALL push {mc_inst, PC}, set PC to PC+4 (mod 2^32, wrapping at 32'hFFFF_FFFC to 0), and return to IDLE.
REQ-020 fetch_req SHALL be 0 in the cycle WAIT -> IDLE; back-to-back fetches are therefore spaced at least 1 idle cycle apart.
REQ-021 mc_done while in IDLE SHALL be ignored.
REQ-022 dec_valid SHALL equal queue non-empty; dec_inst and dec_pc SHALL come combinationally from the head entry.
REQ-023 A pop SHALL occur when dec_valid and dec_ready are both 1.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-025 There is no bypass: an instruction pushed into an empty queue SHALL appear on dec_valid the next cycle.
REQ-026 A request SHALL never be issued at count = QUEUE_DEPTH.
REQ-027 Only one request may be in flight at a time, so a push can never hit a full queue.
REQ-028 On clr=1 (rdy=1), the block SHALL, next cycle: empty the queue, set PC to clr_pc, set the FSM to IDLE and fetch_req to 0.
REQ-029 clr has priority over any simultaneous mc_done, push or pop; data from that mc_done SHALL be discarded.
REQ-030 The memory controller also aborts on clr, so no stale mc_done follows.
REQ-031 When rdy=0, PC, FSM and queue SHALL hold, and mc_done and dec_ready SHALL be ignored.
REQ-032 When rdy=0, outputs SHALL reflect the held state.

Reset
REQ-033 While rst=0: PC=RESET_PC, FSM=IDLE, queue empty, fetch_req=0, fetch_addr=0, dec_valid=0, dec_inst=0, dec_pc=0.
REQ-034 Reset SHALL take effect asynchronously, including in the middle of a WAIT.
REQ-035 The first request SHALL occur in the first rising edge with rst=1 and rdy=1.

Structure
REQ-036 InstWidth (32), AddrWidth (32) and the FSM state encodings SHALL live in the shared defines.v.
REQ-037 The FIFO SHALL be a sub-module inst_queue (parameter QUEUE_DEPTH) with ports push, pop, flush, full, empty and data.
REQ-038 The PC/FSM logic SHALL live in inst_fetcher.

Verification
REQ-039 Reset release, rdy=1, mc_done 2 cycles after each request -> fetch_addr sequence 0x0, 0x4, 0x8; dec_pc 0x0 carries the first mc_inst.
REQ-040 dec_ready=0, 16 fetches completed -> count=16, fetch_req stays 0. Then one pop -> exactly one new request, at 0x40.
REQ-041 clr=1 with clr_pc=0x1000 in the same cycle as mc_done -> queue empty, word dropped, next fetch_addr=0x1000.
REQ-042 rdy=0 for 5 cycles during WAIT with mc_done pulsed -> no push, PC unchanged, request still pending after rdy=1.
REQ-043 rst asserted mid-WAIT with 3 entries queued -> dec_valid=0 and fetch_req=0 immediately; after release, fetch_addr=RESET_PC.
REQ-044 PC=0xFFFF_FFFC, fetch completes -> next fetch_addr=0x0000_0000.
